// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - slice-serial magnitude comparator with cascade inputs and early exit
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             BUSY,
  output logic             DONE,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       casc_q, casc_d;   // {ALBi, AGBi, AEBi} captured at accept
  logic [2:0]       res_q, res_d;     // {ALBo, AGBo, AEBo}

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the slice compare below is always unsigned.
  logic [WIDTH-1:0] sign_flip;
  logic [SLICE-1:0] slice_a, slice_b;

  // Sign-bit mask applied to the operands as they are captured
  always_comb begin
    sign_flip = '0;
    sign_flip[WIDTH-1] = SIGNED;
  end

  assign slice_a = a_q[idx_q*SLICE +: SLICE];
  assign slice_b = b_q[idx_q*SLICE +: SLICE];

  // Next-state logic: capture on accept, walk slices MS first, exit on first difference
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    casc_d  = casc_q;
    res_d   = res_q;
    case (state_q)
      S_SCAN: begin
        if (slice_a != slice_b) begin
          res_d   = {slice_a < slice_b, slice_a > slice_b, 1'b0};
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          res_d   = casc_q;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise
        if (START) begin
          a_d     = A ^ sign_flip;
          b_d     = B ^ sign_flip;
          casc_d  = {ALBi, AGBi, AEBi};
          idx_d   = IDX_TOP;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State register with synchronous reset that also aborts an active scan
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IDX_TOP;
      casc_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
    end
  end

  assign BUSY = (state_q == S_SCAN);
  assign DONE = (state_q == S_DONE);
  assign ALBo = res_q[2];
  assign AGBo = res_q[1];
  assign AEBo = res_q[0];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb/tb_seq_mag_comparator.sv - randomized self-checking bench for seq_mag_comparator
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [31:0] a_v, b_v;
  logic        sgn;
  logic [2:0]  casc;          // {ALBi, AGBi, AEBi}
  logic [2:0]  busy_w, done_w;
  logic [2:0][2:0] res_w;     // per instance {ALBo, AGBo, AEBo}

  int total = 0;
  int bad   = 0;
  int wid [3] = '{16, 8, 32};
  int slc [3] = '{4, 1, 8};
  logic [2:0] prev_res [3];

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(16), .SLICE(4)) dut16 (
    .CLK(clk), .RST(rst), .START(start[0]), .A(a_v[15:0]), .B(b_v[15:0]), .SIGNED(sgn),
    .ALBi(casc[2]), .AGBi(casc[1]), .AEBi(casc[0]), .BUSY(busy_w[0]), .DONE(done_w[0]),
    .ALBo(res_w[0][2]), .AGBo(res_w[0][1]), .AEBo(res_w[0][0]));

  seq_mag_comparator #(.WIDTH(8), .SLICE(1)) dut8 (
    .CLK(clk), .RST(rst), .START(start[1]), .A(a_v[7:0]), .B(b_v[7:0]), .SIGNED(sgn),
    .ALBi(casc[2]), .AGBi(casc[1]), .AEBi(casc[0]), .BUSY(busy_w[1]), .DONE(done_w[1]),
    .ALBo(res_w[1][2]), .AGBo(res_w[1][1]), .AEBo(res_w[1][0]));

  seq_mag_comparator #(.WIDTH(32), .SLICE(8)) dut32 (
    .CLK(clk), .RST(rst), .START(start[2]), .A(a_v), .B(b_v), .SIGNED(sgn),
    .ALBi(casc[2]), .AGBi(casc[1]), .AEBi(casc[0]), .BUSY(busy_w[2]), .DONE(done_w[2]),
    .ALBo(res_w[2][2]), .AGBo(res_w[2][1]), .AEBo(res_w[2][0]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 50) $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: arithmetic compare of the operands' numeric values; latency from
  // the position of the most significant differing bit.
  task automatic model(input int w, input int s, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic [2:0] cin,
                       output logic [2:0] r, output int lat);
    longint m, av, bv, d;
    int p;
    m  = (64'sd1 <<< w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sg && ((av >>> (w - 1)) & 1) == 1) av = av - (64'sd1 <<< w);
    if (sg && ((bv >>> (w - 1)) & 1) == 1) bv = bv - (64'sd1 <<< w);
    if (av < bv)      r = 3'b100;
    else if (av > bv) r = 3'b010;
    else              r = cin;
    d = (longint'(a ^ b)) & m;
    if (d == 0) lat = w / s;
    else begin
      p = 0;
      for (int i = 0; i < w; i++) if (((d >>> i) & 1) == 1) p = i;
      lat = w / s - p / s;
    end
  endtask

  // One request on instance k; leaves the instance in its DONE cycle so the
  // next call is accepted back-to-back on the following edge.
  task automatic txn(input int k, input logic [31:0] a, input logic [31:0] b, input logic sg,
                     input logic [2:0] cin, input bit pulses,
                     input logic [2:0] exp_res, input int exp_lat);
    int lat;
    a_v = a; b_v = b; sgn = sg; casc = cin;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    a_v = $urandom; b_v = $urandom; sgn = 1'($urandom); casc = 3'($urandom);
    check("busy_after_accept", {31'd0, busy_w[k]}, 32'd1);
    lat = 0;
    while (1) begin
      if (pulses) begin
        start[k] = 1'($urandom);
        a_v = $urandom; b_v = $urandom; sgn = 1'($urandom); casc = 3'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done_w[k]) break;
      check("res_stable_in_scan", {29'd0, res_w[k]}, {29'd0, prev_res[k]});
      if (lat > wid[k] / slc[k] + 2) begin
        check("done_timeout", lat, exp_lat);
        break;
      end
    end
    start[k] = 1'b0;
    check("latency", lat, exp_lat);
    check("result", {29'd0, res_w[k]}, {29'd0, exp_res});
    check("busy_in_done", {31'd0, busy_w[k]}, 32'd0);
    prev_res[k] = exp_res;
  endtask

  task automatic rtxn(input int k, input logic [31:0] a, input logic [31:0] b, input logic sg,
                      input logic [2:0] cin, input bit pulses);
    logic [2:0] r;
    int lat;
    model(wid[k], slc[k], a, b, sg, cin, r, lat);
    txn(k, a, b, sg, cin, pulses, r, lat);
  endtask

  task automatic random_run(input int k, input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      case ($urandom_range(3))
        0: b = a ^ (32'd1 << $urandom_range(wid[k] - 1));
        1: b = (i % 7 == 0) ? a : $urandom;
        default: b = $urandom;
      endcase
      rtxn(k, a, b, 1'($urandom), 3'($urandom), ($urandom_range(7) == 0));
    end
  endtask

  initial begin
    rst = 1'b1; start = '0; a_v = '0; b_v = '0; sgn = 1'b0; casc = '0;
    for (int k = 0; k < 3; k++) prev_res[k] = 3'b000;
    start[0] = 1'b1;                       // reset must override START
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", {31'd0, busy_w[k]}, 32'd0);
      check("reset_done", {31'd0, done_w[k]}, 32'd0);
      check("reset_res", {29'd0, res_w[k]}, 32'd0);
    end
    start[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases on the 16/4 instance
    txn(0, 32'h1234, 32'h1235, 1'b0, 3'b001, 1'b0, 3'b100, 4);
    txn(0, 32'h8000, 32'h0001, 1'b0, 3'b000, 1'b0, 3'b010, 1);
    txn(0, 32'h8000, 32'h0001, 1'b1, 3'b000, 1'b0, 3'b100, 1);
    txn(0, 32'hBEEF, 32'hBEEF, 1'b0, 3'b001, 1'b0, 3'b001, 4);
    txn(0, 32'hBEEF, 32'hBEEF, 1'b0, 3'b110, 1'b1, 3'b110, 4);
    txn(0, 32'h7F00, 32'h7E00, 1'b1, 3'b001, 1'b1, 3'b010, 2);
    txn(0, 32'hFFF0, 32'h0010, 1'b1, 3'b010, 1'b1, 3'b100, 1);

    // Abort: reset during the second SCAN cycle of a 4-cycle scan
    a_v = 32'h1111; b_v = 32'h1111; sgn = 1'b0; casc = 3'b001;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    check("abort_res", {29'd0, res_w[0]}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("abort_no_done", {31'd0, done_w[0]}, 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) prev_res[k] = 3'b000;
    txn(0, 32'h1111, 32'h1111, 1'b0, 3'b001, 1'b0, 3'b001, 4);
    random_run(0, 300);
    @(posedge clk); #1;

    // Parameter sweep instances
    random_run(1, 10000);
    @(posedge clk); #1;
    random_run(2, 10000);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of SLICE and >= SLICE.
REQ-002 Parameter SLICE, default 4, bits compared per clock; SHALL be >= 1.
REQ-003 Derived NSLICE = WIDTH/SLICE, the number of slices; SHALL be computed internally, not a port.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 RST  input  1  synchronous reset, active-high, sampled on the rising edge of CLK.
REQ-006 START  input  1  request; SHALL be accepted only in IDLE or DONE state.
REQ-007 A  input  WIDTH  operand A; SHALL be sampled only on the accepting edge.
REQ-008 B  input  WIDTH  operand B; SHALL be sampled only on the accepting edge.
REQ-009 SIGNED  input  1  1 = two's-complement compare, 0 = unsigned; SHALL be sampled with A/B.
REQ-010 ALBi, AGBi, AEBi  input  1 each  cascade inputs from a lower-order stage; SHALL be sampled with A/B.
REQ-011 BUSY  output  1  high while a compare is in progress (SCAN state).
REQ-012 DONE  output  1  one-cycle pulse; result valid.
REQ-013 ALBo, AGBo, AEBo  output  1 each  registered result (A<B, A>B, A==B); SHALL hold until the next accepted START.

Function
REQ-014 States SHALL be IDLE, SCAN and DONE; only one state is active per cycle.
REQ-015 IDLE + START SHALL capture A, B, SIGNED and the cascade inputs, set slice index j=NSLICE-1 (MS slice) and go to SCAN; BUSY=1 the next cycle.
REQ-016 SCAN SHALL compare slice j, bits [j*SLICE+SLICE-1 : j*SLICE], of the captured operands, one slice per cycle, MS slice first.
REQ-017 With SIGNED=1, bit WIDTH-1 of both captured operands SHALL be inverted before slice compare; with SIGNED=0, bits are used as-is.
REQ-018 If slice j differs, the edge ending that cycle SHALL register ALBo/AGBo from that slice (AEBo=0) and enter DONE; the remaining slices are skipped (early exit).
REQ-019 If slice j is equal and j>0, SCAN SHALL continue with j-1.
REQ-020 If slice 0 is equal, outputs SHALL take ALBo=ALBi, AGBo=AGBi, AEBo=AEBi (captured values, passed unmodified even if inconsistent), then enter DONE.
REQ-021 Latency: a result decided at slice index j SHALL give DONE=1 exactly NSLICE-j cycles after the accepting edge; worst case NSLICE cycles.
REQ-022 DONE SHALL last exactly one cycle with BUSY=0; the next state is IDLE, or SCAN if START=1 in that cycle (back-to-back, no bubble).
REQ-023 START during SCAN SHALL be ignored, with no effect on the operands, index or outputs.
REQ-024 Result outputs SHALL change only on the edge that enters DONE; they are stable in IDLE and SCAN.
REQ-025 Exactly one of ALBo/AGBo/AEBo SHALL be 1 whenever a slice decided the result.

Reset
REQ-026 RST=1 SHALL force IDLE, BUSY=0, DONE=0, ALBo=0, AGBo=0, AEBo=0, j=NSLICE-1 on the next edge.
REQ-027 RST SHALL override START on the same edge.
REQ-028 RST during SCAN SHALL abort the compare; no DONE pulse is produced for it.

Verification
REQ-029 WIDTH=16,SLICE=4,SIGNED=0: A=0x1234,B=0x1235,AEBi=1 -> DONE at cycle 4, ALBo=1,AGBo=0,AEBo=0.
REQ-030 A=0x8000,B=0x0001: SIGNED=0 -> DONE at cycle 1, AGBo=1; SIGNED=1 -> DONE at cycle 1, ALBo=1.
REQ-031 A=B=0xBEEF: with ALBi=0,AGBi=0,AEBi=1 -> DONE at cycle 4, AEBo=1; with ALBi=1,AGBi=1,AEBi=0 -> ALBo=1,AGBo=1,AEBo=0.
REQ-032 START held high: one compare followed by a second, START accepted in the DONE cycle -> the second BUSY starts the next cycle; START pulses during SCAN leave the result unchanged.
REQ-033 RST asserted at cycle 2 of a 4-cycle scan -> no DONE; outputs 0/0/0; a fresh START afterwards completes normally.
REQ-034 Parameter sweep WIDTH=8,SLICE=1 and WIDTH=32,SLICE=8 with 10k random signed/unsigned pairs -> result matches the reference compare, and latency matches REQ-021.
